led8_seq: RTL and testbench

//  Pattern sequencer and fader for the led8pwm brightness stage. It steps through a small

---
 rtl/led8_pkg.sv | 34 +++
 rtl/led8_seq_if.sv | 37 +++
 rtl/led8_tick.sv | 35 +++
 rtl/led8_seq.sv | 177 +++++++++++++++++
 tb/tb_led8_seq.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led8_pkg.sv
// Shared types for the led8 blocks: sequencer states, pattern and brightness widths.
// Pure declarations and helpers, no state, no latency.
// Saturating brightness arithmetic used by the fade steps.
package led8_pkg;

   localparam int LED_W = 8;
   localparam int VAL_W = 8;

   typedef logic [LED_W-1:0] led_t;
   typedef logic [VAL_W-1:0] val_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FADE_IN  = 3'd1,
      HOLD     = 3'd2,
      FADE_OUT = 3'd3,
      NEXT     = 3'd4
   } state_e;

   // Brightness step upward, clipped at the configured peak (9-bit sum so 8-bit overflow cannot wrap).
   function automatic val_t sat_add(val_t a, val_t b, val_t lim);
      logic [VAL_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, lim}) return lim;
      return sum[VAL_W-1:0];
   endfunction

   // Brightness step downward, floored at zero.
   function automatic val_t floor_sub(val_t a, val_t b);
      if (a > b) return a - b;
      return '0;
   endfunction

endpackage

// File: rtl/led8_seq_if.sv
// Control/status bundle between a host and the led8 sequencer.
// Wires only, no latency.
// No backpressure: writes and start/stop are single-cycle strobes.
interface led8_seq_if #(
   parameter int AW = 4
);
   import led8_pkg::*;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   led_t          wr_data;
   logic [AW-1:0] last;
   logic [15:0]   hold_t;
   val_t          fade_step;
   val_t          max_val;
   logic          loop;
   logic          start;
   logic          stop;
   logic          busy;
   logic          done;
   logic [AW-1:0] index;
   led_t          led;
   val_t          val;

   // Host side: drives table writes, configuration and strobes.
   modport master (
      output wr_en, wr_addr, wr_data, last, hold_t, fade_step, max_val, loop, start, stop,
      input  busy, done, index, led, val
   );

   // Sequencer side.
   modport slave (
      input  wr_en, wr_addr, wr_data, last, hold_t, fade_step, max_val, loop, start, stop,
      output busy, done, index, led, val
   );

endinterface

// File: rtl/led8_tick.sv
// Prescaler: one-cycle tick every CLK_HZ/TICK_HZ enabled cycles.
// tick is combinational from the counter, asserted on the last count of each period.
// en low clears the count so the next period starts from a fresh phase.
module led8_tick #(
   parameter int CLK_HZ  = 48000000,
   parameter int TICK_HZ = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int PRESCALE = CLK_HZ / TICK_HZ;
   localparam int CW       = $clog2(PRESCALE);
   localparam logic [CW-1:0] CNT_TOP = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: hold at zero while disabled, wrap at the end of each period.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!en || cnt_q == CNT_TOP) cnt_d = '0;
   end

   // Prescaler counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick = en && (cnt_q == CNT_TOP);

endmodule

// File: rtl/led8_seq.sv
// Pattern sequencer/fader: plays table entries as fade-in, hold, fade-out for led8pwm.
// Outputs are registered; start/stop take effect on the next clock edge.
// No backpressure; table writes are accepted every cycle, stop overrides start.
module led8_seq #(
   parameter int CLK_HZ  = 48000000,
   parameter int TICK_HZ = 1000,
   parameter int DEPTH   = 16
) (
   input  logic        clk,
   input  logic        rst,
   led8_seq_if.slave   bus
);
   import led8_pkg::*;

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

   state_e        state_q;
   logic          busy_q;
   logic          done_q;
   logic [AW-1:0] index_q;
   led_t          led_q;
   val_t          val_q;
   logic [15:0]   hold_q;

   // Configuration captured at start so mid-run input changes do not disturb playback.
   logic [AW-1:0] last_q;
   logic [15:0]   hold_t_q;
   val_t          step_q;
   val_t          max_q;
   logic          loop_q;

   led_t          table_q [DEPTH];

   logic          tick;
   logic          tick_en;
   val_t          val_up_d;
   val_t          val_dn_d;
   logic [AW-1:0] index_d;
   logic [AW-1:0] last_d;
   logic [AW-1:0] rd_addr;
   led_t          rd_dat;

   // A start or stop restarts the tick phase; the counter also idles at zero.
   assign tick_en = busy_q && !bus.start && !bus.stop;

   led8_tick #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .tick (tick)
   );

   // Next-step values: fade arithmetic, next entry index, clamped last, table read address.
   always_comb begin
      val_up_d = sat_add(val_q, step_q, max_q);
      val_dn_d = floor_sub(val_q, step_q);
      index_d  = (index_q < last_q) ? index_q + 1'b1 : '0;
      last_d   = (bus.last > LAST_MAX) ? LAST_MAX : bus.last;
      rd_addr  = bus.start ? '0 : index_d;
   end

   // Read sees the pre-write contents, so a same-cycle write and load returns old data.
   assign rd_dat = table_q[rd_addr];

   // Pattern table: single synchronous write port, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      end else if (bus.wr_en) begin
         table_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Playback FSM with registered outputs; stop beats start, start beats normal stepping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         index_q  <= '0;
         led_q    <= '0;
         val_q    <= '0;
         hold_q   <= '0;
         last_q   <= '0;
         hold_t_q <= '0;
         step_q   <= '0;
         max_q    <= '0;
         loop_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            index_q <= '0;
            led_q   <= '0;
            val_q   <= '0;
            hold_q  <= '0;
         end else if (bus.start) begin
            state_q  <= FADE_IN;
            busy_q   <= 1'b1;
            index_q  <= '0;
            led_q    <= rd_dat;
            val_q    <= '0;
            hold_q   <= '0;
            last_q   <= last_d;
            hold_t_q <= bus.hold_t;
            step_q   <= bus.fade_step;
            max_q    <= bus.max_val;
            loop_q   <= bus.loop;
         end else begin
            case (state_q)
               IDLE: begin
                  busy_q <= 1'b0;
               end
               FADE_IN: begin
                  // A zero step or zero peak would never converge by ticks; jump straight up.
                  if (step_q == '0 || max_q == '0) begin
                     val_q   <= max_q;
                     state_q <= HOLD;
                  end else if (tick) begin
                     val_q <= val_up_d;
                     if (val_up_d == max_q) state_q <= HOLD;
                  end
               end
               HOLD: begin
                  if (hold_t_q == '0) begin
                     state_q <= FADE_OUT;
                  end else if (tick) begin
                     if (hold_q == hold_t_q - 16'd1) begin
                        hold_q  <= '0;
                        state_q <= FADE_OUT;
                     end else begin
                        hold_q <= hold_q + 16'd1;
                     end
                  end
               end
               FADE_OUT: begin
                  if (step_q == '0 || val_q == '0) begin
                     val_q   <= '0;
                     state_q <= NEXT;
                  end else if (tick) begin
                     val_q <= val_dn_d;
                     if (val_dn_d == '0) state_q <= NEXT;
                  end
               end
               NEXT: begin
                  if (index_q < last_q || loop_q) begin
                     index_q <= index_d;
                     led_q   <= rd_dat;
                     state_q <= FADE_IN;
                  end else begin
                     led_q   <= '0;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.index = index_q;
   assign bus.led   = led_q;
   assign bus.val   = val_q;

endmodule

// File: tb/tb_led8_seq.sv
// Bench for led8_seq: expected (index, led, val) tuples are queued as stimulus is issued
// and compared in order whenever the DUT outputs change; done pulses are counted separately.
module tb_led8_seq;
   import led8_pkg::*;

   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   led8_seq_if #(.AW(AW)) bus ();

   led8_seq #(
      .CLK_HZ  (1000),
      .TICK_HZ (250),
      .DEPTH   (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int t_start = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_last = 32'h0;
   logic [31:0] prev_t = 32'h0;
   logic [31:0] cur_t;
   logic [7:0]  mtbl [16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] tup(input int i, input int l, input int v);
      logic [3:0] ii = i[3:0];
      logic [7:0] ll = l[7:0];
      logic [7:0] vv = v[7:0];
      return {12'h0, ii, ll, vv};
   endfunction

   // Queue a tuple only when it differs from the last one, since the monitor sees changes only.
   function automatic void push(input logic [31:0] t);
      if (t != exp_last) begin
         exp_q.push_back(t);
         exp_last = t;
      end
   endfunction

   function automatic void push_entry(input int idx, input int l, input int step, input int mx,
                                      input bit in_only);
      int v = 0;
      push(tup(idx, l, 0));
      if (step == 0 || mx == 0) begin
         v = mx;
         push(tup(idx, l, v));
      end else begin
         while (v != mx) begin
            v = (v + step > mx) ? mx : v + step;
            push(tup(idx, l, v));
         end
      end
      if (!in_only) begin
         if (step == 0) begin
            v = 0;
            push(tup(idx, l, v));
         end else begin
            while (v != 0) begin
               v = (v > step) ? v - step : 0;
               push(tup(idx, l, v));
            end
         end
      end
   endfunction

   function automatic void push_pass(input int last, input int step, input int mx);
      for (int i = 0; i <= last; i++) push_entry(i, mtbl[i], step, mx, 1'b0);
   endfunction

   // Output monitor: compare every change of (index, led, val) against the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         cur_t = tup(bus.index, bus.led, bus.val);
         if (cur_t != prev_t) begin
            if (exp_q.size() > 0) chk("seq", cur_t, exp_q.pop_front());
            else                  chk("seq_extra", cur_t, prev_t);
            prev_t = cur_t;
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_with_done", {31'b0, bus.busy}, 32'd0);
         end
      end
   end

   task automatic cfg(input int last, input int hold, input int step, input int mx, input bit lp);
      bus.last      = last[AW-1:0];
      bus.hold_t    = hold[15:0];
      bus.fade_step = step[7:0];
      bus.max_val   = mx[7:0];
      bus.loop      = lp;
   endtask

   task automatic wr(input int a, input int d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a[AW-1:0];
      bus.wr_data = d[7:0];
      @(negedge clk);
      bus.wr_en   = 1'b0;
      mtbl[a]     = d[7:0];
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      t_start   = cyc;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
   endtask

   task automatic wait_empty(input int lim, input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, exp_q.size(), 0);
      if (exp_q.size() != 0) begin
         exp_q.delete();
         exp_last = tup(bus.index, bus.led, bus.val);
      end
   endtask

   task automatic wait_val(input int v, input int lim, input string tag);
      int n = 0;
      while (bus.val != v[7:0] && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {24'h0, bus.val}, v);
   endtask

   task automatic wait_idx(input int v, input int lim, input string tag);
      int n = 0;
      while (bus.index != v[AW-1:0] && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {28'h0, bus.index}, v);
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_led"},  {24'h0, bus.led},   32'd0);
      chk({tag, "_val"},  {24'h0, bus.val},   32'd0);
      chk({tag, "_idx"},  {28'h0, bus.index}, 32'd0);
      chk({tag, "_busy"}, {31'b0, bus.busy},  32'd0);
      chk({tag, "_done"}, {31'b0, bus.done},  32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 1'b0; bus.stop = 1'b0;
      cfg(0, 0, 0, 0, 1'b0);
      for (int i = 0; i < 16; i++) mtbl[i] = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_idle_zero("reset");

      // 1: three entries, single non-looping pass
      wr(0, 8'h01); wr(1, 8'h02); wr(2, 8'h04);
      cfg(2, 2, 64, 128, 1'b0);
      push_pass(2, 64, 128);
      push(tup(2, 0, 0));
      done_cnt = 0;
      pulse_start();
      wait_val(128, 100, "t1_reach_max");
      n = 0;
      while (bus.val == 8'd128 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t1_hold_len", n, 12);
      wait_empty(400, "t1_seq_drained");
      repeat (2) @(negedge clk);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_busy", {31'b0, bus.busy}, 32'd0);

      // 2: looping, three full passes then stop while holding the first entry
      cfg(2, 2, 64, 128, 1'b1);
      for (int p = 0; p < 3; p++) push_pass(2, 64, 128);
      push_entry(0, mtbl[0], 64, 128, 1'b1);
      done_cnt = 0;
      pulse_start();
      wait_empty(1500, "t2_seq_drained");
      pulse_stop();
      push(tup(0, 0, 0));
      wait_empty(10, "t2_stop_seq");
      chk("t2_done_cnt", done_cnt, 0);
      chk("t2_busy", {31'b0, bus.busy}, 32'd0);

      // 3: saturating fade-in and flooring fade-out
      cfg(0, 1, 100, 255, 1'b0);
      push_entry(0, mtbl[0], 100, 255, 1'b0);
      push(tup(0, 0, 0));
      done_cnt = 0;
      pulse_start();
      wait_empty(200, "t3_seq_drained");
      repeat (2) @(negedge clk);
      chk("t3_done_cnt", done_cnt, 1);

      // 4: zero step and zero hold -> fixed four cycles per entry
      cfg(2, 0, 0, 200, 1'b0);
      push_pass(2, 0, 200);
      push(tup(2, 0, 0));
      done_cnt = 0;
      pulse_start();
      wait_empty(100, "t4_seq_drained");
      repeat (2) @(negedge clk);
      chk("t4_done_cnt", done_cnt, 1);
      chk("t4_run_len", done_cyc - t_start, 12);

      // 5: stop during hold, then stop+start together
      cfg(2, 2, 64, 128, 1'b0);
      push_entry(0, mtbl[0], 64, 128, 1'b1);
      done_cnt = 0;
      pulse_start();
      wait_empty(100, "t5_reach_hold");
      pulse_stop();
      push(tup(0, 0, 0));
      chk_idle_zero("t5_stop");
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      repeat (10) @(negedge clk);
      chk("t5_startstop_busy", {31'b0, bus.busy}, 32'd0);
      chk("t5_done_cnt", done_cnt, 0);
      wait_empty(5, "t5_no_change");

      // 6: write displayed entry mid-pass; visible only on the next pass
      cfg(2, 2, 64, 128, 1'b1);
      push_pass(2, 64, 128);
      mtbl[1] = 8'hFF;
      push_pass(2, 64, 128);
      push_entry(0, mtbl[0], 64, 128, 1'b1);
      pulse_start();
      wait_idx(1, 200, "t6_reach_idx1");
      wr(1, 8'hFF);
      wait_empty(1000, "t6_seq_drained");
      pulse_stop();
      push(tup(0, 0, 0));
      wait_empty(10, "t6_stop_seq");

      // 6b: reset during fade-in clears outputs and the table
      cfg(2, 2, 64, 128, 1'b0);
      push(tup(0, mtbl[0], 0));
      push(tup(0, mtbl[0], 64));
      pulse_start();
      wait_empty(100, "t6_fade_in");
      rst = 1'b1;
      for (int i = 0; i < 16; i++) mtbl[i] = 8'h00;
      push(tup(0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      chk_idle_zero("t6_rst");
      cfg(2, 0, 0, 128, 1'b0);
      push_pass(2, 0, 128);
      push(tup(2, 0, 0));
      done_cnt = 0;
      pulse_start();
      wait_empty(100, "t6_table_cleared");
      repeat (2) @(negedge clk);
      chk("t6_done_cnt", done_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
